multi_tank_overlay: RTL and testbench

MULTI_TANK_OVERLAY -- requirements
Module: multi_tank_overlay

---
 rtl/multi_tank_overlay.sv | 192 +++++++++++++++++++
 tb/tb_multi_tank_overlay.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_tank_overlay.sv
// Overlays up to N_TANKS opponent tank sprites on a video stream. Positions are
// double-buffered and committed once per frame at the vblank rising edge.
module multi_tank_overlay #(
  parameter int unsigned N_TANKS   = 2,
  parameter int unsigned SPR_W     = 64,
  parameter int unsigned SPR_H     = 64,
  parameter int unsigned COORD_W   = 10,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [10:0]                           hcount,
  input  logic [9:0]                            vcount,
  input  logic                                  hsync,
  input  logic                                  vsync,
  input  logic                                  hblnk,
  input  logic                                  vblnk,
  input  logic [11:0]                           rgb_in,
  input  logic                                  select,
  input  logic                                  pos_valid,
  output logic                                  pos_ready,
  input  logic [2:0]                            pos_id,
  input  logic [COORD_W-1:0]                    pos_x,
  input  logic [COORD_W-1:0]                    pos_y,
  input  logic                                  pos_alive,
  output logic [$clog2(SPR_W*SPR_H)-1:0]        pixel_addr,
  input  logic [11:0]                           rgb_pixel,
  output logic [10:0]                           hcount_out,
  output logic [9:0]                            vcount_out,
  output logic                                  hsync_out,
  output logic                                  vsync_out,
  output logic                                  hblnk_out,
  output logic                                  vblnk_out,
  output logic                                  select_out,
  output logic [11:0]                           rgb_out,
  output logic                                  overlap_flag
);

  localparam int unsigned AW = $clog2(SPR_W*SPR_H);
  localparam int unsigned SW = (COORD_W + 2 > 12) ? COORD_W + 2 : 12;
  localparam int unsigned TW = 11 + 10 + 5 + 12;

  logic [COORD_W-1:0] sh_x  [N_TANKS];
  logic [COORD_W-1:0] sh_y  [N_TANKS];
  logic [COORD_W-1:0] act_x [N_TANKS];
  logic [COORD_W-1:0] act_y [N_TANKS];
  logic [N_TANKS-1:0] sh_alive, act_alive;

  logic vblnk_q, commit_q, sticky;
  logic vblnk_rise_c;

  logic [N_TANKS-1:0] cover_c;
  logic               hit_c, multi_c;
  logic [COORD_W-1:0] win_x, win_y;
  logic [SW-1:0]      h_ext, v_ext, dx_c, dy_c;
  logic [AW-1:0]      addr_c;

  logic [TW-1:0] s1_t, s2_t;
  logic          s1_hit, s2_hit;
  logic [10:0]   s2_hc;
  logic [9:0]    s2_vc;
  logic          s2_hs, s2_vs, s2_hb, s2_vb, s2_sel;
  logic [11:0]   s2_rgb;
  logic          draw_c;

  assign vblnk_rise_c = vblnk & ~vblnk_q;

  // Frame commit timing, write handshake and overlap bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q      <= 1'b0;
      commit_q     <= 1'b0;
      pos_ready    <= 1'b0;
      sticky       <= 1'b0;
      overlap_flag <= 1'b0;
    end else begin
      vblnk_q   <= vblnk;
      commit_q  <= vblnk_rise_c;
      pos_ready <= ~vblnk_rise_c;
      if (commit_q) begin
        overlap_flag <= sticky;
        sticky       <= 1'b0;
      end else if (multi_c && select && !hblnk && !vblnk) begin
        sticky <= 1'b1;
      end
    end
  end

  // Shadow writes; ids beyond N_TANKS match no channel and are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_TANKS); i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_alive  <= '0;
      act_alive <= '0;
    end else begin
      if (commit_q) begin
        for (int i = 0; i < int'(N_TANKS); i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
        end
        act_alive <= sh_alive;
      end
      if (pos_valid && pos_ready) begin
        for (int i = 0; i < int'(N_TANKS); i++) begin
          if (pos_id == 3'(i)) begin
            sh_x[i]     <= pos_x;
            sh_y[i]     <= pos_y;
            sh_alive[i] <= pos_alive;
          end
        end
      end
    end
  end

  assign h_ext = SW'(hcount);
  assign v_ext = SW'(vcount);

  // Sprite bounds evaluated wide enough that a sprite near the edge never wraps
  for (genvar g = 0; g < int'(N_TANKS); g++) begin : g_cov
    logic [SW-1:0] x_lo, y_lo;
    assign x_lo = SW'(act_x[g]);
    assign y_lo = SW'(act_y[g]);
    assign cover_c[g] = act_alive[g] &&
                        (h_ext >= x_lo) && (h_ext < x_lo + SW'(SPR_W)) &&
                        (v_ext >= y_lo) && (v_ext < y_lo + SW'(SPR_H));
  end

  // Lowest covering index wins; any second cover flags an overlap
  always_comb begin
    hit_c   = 1'b0;
    multi_c = 1'b0;
    win_x   = '0;
    win_y   = '0;
    for (int i = 0; i < int'(N_TANKS); i++) begin
      if (cover_c[i]) begin
        if (hit_c) begin
          multi_c = 1'b1;
        end else begin
          hit_c = 1'b1;
          win_x = act_x[i];
          win_y = act_y[i];
        end
      end
    end
  end

  assign dx_c   = h_ext - SW'(win_x);
  assign dy_c   = v_ext - SW'(win_y);
  assign addr_c = hit_c ? (AW'(dy_c) * AW'(SPR_W) + AW'(dx_c)) : '0;

  assign {s2_hc, s2_vc, s2_hs, s2_vs, s2_hb, s2_vb, s2_sel, s2_rgb} = s2_t;
  assign draw_c = s2_hit && s2_sel && !(s2_hb || s2_vb) && (rgb_pixel != KEY_COLOR);

  // Three-stage video pipeline; stage 2 waits for the ROM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_t       <= '0;
      s1_hit     <= 1'b0;
      pixel_addr <= '0;
      s2_t       <= '0;
      s2_hit     <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      select_out <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      s1_t       <= {hcount, vcount, hsync, vsync, hblnk, vblnk, select, rgb_in};
      s1_hit     <= hit_c;
      pixel_addr <= addr_c;
      s2_t       <= s1_t;
      s2_hit     <= s1_hit;
      hcount_out <= s2_hc;
      vcount_out <= s2_vc;
      hsync_out  <= s2_hs;
      vsync_out  <= s2_vs;
      hblnk_out  <= s2_hb;
      vblnk_out  <= s2_vb;
      select_out <= s2_sel;
      rgb_out    <= draw_c ? rgb_pixel : s2_rgb;
    end
  end

endmodule

// File: tb/tb_multi_tank_overlay.sv
// Directed bench for multi_tank_overlay with a synchronous sprite ROM model.
module tb_multi_tank_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, hblnk, vblnk, select;
  logic [11:0] rgb_in;
  logic        pos_valid, pos_ready, pos_alive;
  logic [2:0]  pos_id;
  logic [9:0]  pos_x, pos_y;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel = 12'h000;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, select_out;
  logic [11:0] rgb_out;
  logic        overlap_flag;

  int tests = 0;
  int fails = 0;
  logic key_mode = 1'b0;

  always #5 clk = ~clk;

  // ROM content: bit 11 set plus low 11 address bits, or all key colour
  always @(posedge clk) rgb_pixel <= key_mode ? 12'h000 : {1'b1, pixel_addr[10:0]};

  multi_tank_overlay #(
    .N_TANKS(2), .SPR_W(64), .SPR_H(64), .COORD_W(10), .KEY_COLOR(12'h000)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .rgb_in(rgb_in), .select(select),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_id(pos_id),
    .pos_x(pos_x), .pos_y(pos_y), .pos_alive(pos_alive),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .select_out(select_out), .rgb_out(rgb_out), .overlap_flag(overlap_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel, then filler; address checked after 1 edge, video after 3
  task automatic probe(input string tag, input logic [10:0] h, input logic [9:0] v,
                       input logic [11:0] rin, input logic sel, input logic hb,
                       input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    hcount = h; vcount = v; rgb_in = rin; select = sel; hblnk = hb;
    @(posedge clk); #1;
    check({tag, "_addr"}, 32'(pixel_addr), 32'(exp_addr));
    hcount = 11'd2000; vcount = 10'd1000; rgb_in = 12'hFFF; select = 1'b0; hblnk = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
    check({tag, "_hcnt"}, 32'(hcount_out), 32'(h));
  endtask

  task automatic write_pos(input logic [2:0] id, input logic [9:0] x, input logic [9:0] y,
                           input logic alive);
    pos_id = id; pos_x = x; pos_y = y; pos_alive = alive; pos_valid = 1'b1;
    @(posedge clk); #1;
    pos_valid = 1'b0;
  endtask

  task automatic commit_frame();
    vblnk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0;
    hblnk = 1'b0; vblnk = 1'b0; rgb_in = '0; select = 1'b0;
    pos_valid = 1'b0; pos_id = '0; pos_x = '0; pos_y = '0; pos_alive = 1'b0;

    #12;
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_hsync", 32'(hsync_out), 32'h0);
    check("rst_ready", 32'(pos_ready), 32'h0);
    check("rst_flag", 32'(overlap_flag), 32'h0);
    check("rst_addr", 32'(pixel_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(pos_ready), 32'h1);

    probe("no_tank", 11'd100, 10'd50, 12'h321, 1'b1, 1'b0, 12'h000, 12'h321);

    // Single tank at (100,50)
    write_pos(3'd0, 10'd100, 10'd50, 1'b1);
    probe("pre_commit", 11'd100, 10'd50, 12'h321, 1'b1, 1'b0, 12'h000, 12'h321);
    commit_frame();
    probe("t0_origin", 11'd100, 10'd50, 12'h321, 1'b1, 1'b0, 12'h000, 12'h800);
    probe("t0_left", 11'd99, 10'd50, 12'h321, 1'b1, 1'b0, 12'h000, 12'h321);
    probe("t0_corner", 11'd163, 10'd113, 12'h321, 1'b1, 1'b0, 12'hFFF, 12'hFFF);
    probe("t0_right", 11'd164, 10'd50, 12'h456, 1'b1, 1'b0, 12'h000, 12'h456);
    probe("t0_below", 11'd100, 10'd114, 12'h457, 1'b1, 1'b0, 12'h000, 12'h457);
    probe("t0_mid", 11'd110, 10'd52, 12'h321, 1'b1, 1'b0, 12'h08A, 12'h88A);
    probe("t0_nosel", 11'd100, 10'd50, 12'h654, 1'b0, 1'b0, 12'h000, 12'h654);
    probe("t0_hblnk", 11'd100, 10'd50, 12'h655, 1'b1, 1'b1, 12'h000, 12'h655);
    key_mode = 1'b1;
    probe("t0_key", 11'd110, 10'd52, 12'h656, 1'b1, 1'b0, 12'h08A, 12'h656);
    key_mode = 1'b0;
    check("flag_none", 32'(overlap_flag), 32'h0);

    // Two tanks on top of each other
    write_pos(3'd0, 10'd200, 10'd200, 1'b1);
    write_pos(3'd1, 10'd200, 10'd200, 1'b1);
    commit_frame();
    probe("ovl_same", 11'd210, 10'd205, 12'h111, 1'b1, 1'b0, 12'h14A, 12'h94A);
    write_pos(3'd1, 10'd190, 10'd195, 1'b1);
    commit_frame();
    check("flag_set", 32'(overlap_flag), 32'h1);
    probe("id1_only", 11'd195, 10'd200, 12'h111, 1'b1, 1'b0, 12'h145, 12'h945);
    commit_frame();
    check("flag_clear", 32'(overlap_flag), 32'h0);
    probe("prio_id0", 11'd210, 10'd205, 12'h111, 1'b1, 1'b0, 12'h14A, 12'h94A);
    write_pos(3'd1, 10'd190, 10'd195, 1'b0);
    commit_frame();
    check("flag_set2", 32'(overlap_flag), 32'h1);
    commit_frame();
    check("flag_clear2", 32'(overlap_flag), 32'h0);

    // Write held across the commit cycle
    vblnk = 1'b1;
    @(posedge clk); #1;
    pos_id = 3'd0; pos_x = 10'd300; pos_y = 10'd300; pos_alive = 1'b1; pos_valid = 1'b1;
    check("ready_commit", 32'(pos_ready), 32'h0);
    @(posedge clk); #1;
    check("ready_after_commit", 32'(pos_ready), 32'h1);
    @(posedge clk); #1;
    pos_valid = 1'b0;
    vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    probe("late_not_yet", 11'd300, 10'd300, 12'h222, 1'b1, 1'b0, 12'h000, 12'h222);
    probe("late_old", 11'd200, 10'd200, 12'h222, 1'b1, 1'b0, 12'h000, 12'h800);
    commit_frame();
    probe("late_applied", 11'd300, 10'd300, 12'h222, 1'b1, 1'b0, 12'h000, 12'h800);
    probe("late_old_gone", 11'd200, 10'd200, 12'h223, 1'b1, 1'b0, 12'h000, 12'h223);

    // Right-edge clipping without wrap
    write_pos(3'd0, 10'd1014, 10'd100, 1'b1);
    commit_frame();
    probe("edge_first", 11'd1014, 10'd100, 12'h333, 1'b1, 1'b0, 12'h000, 12'h800);
    probe("edge_last", 11'd1023, 10'd110, 12'h333, 1'b1, 1'b0, 12'h289, 12'hA89);
    probe("edge_nowrap0", 11'd0, 10'd100, 12'h334, 1'b1, 1'b0, 12'h000, 12'h334);
    probe("edge_nowrap53", 11'd53, 10'd100, 12'h335, 1'b1, 1'b0, 12'h000, 12'h335);

    // Out-of-range id is accepted and dropped
    pos_id = 3'd7; pos_x = 10'd100; pos_y = 10'd50; pos_alive = 1'b1; pos_valid = 1'b1;
    #1;
    check("ready_id7", 32'(pos_ready), 32'h1);
    @(posedge clk); #1;
    pos_valid = 1'b0;
    commit_frame();
    probe("id7_dropped", 11'd100, 10'd50, 12'h444, 1'b1, 1'b0, 12'h000, 12'h444);
    probe("id7_keep", 11'd1014, 10'd100, 12'h444, 1'b1, 1'b0, 12'h000, 12'h800);

    // Reset in the middle of a frame with a pending update
    write_pos(3'd0, 10'd500, 10'd400, 1'b1);
    hcount = 11'd5; vcount = 10'd0; hsync = 1'b1; vsync = 1'b1; select = 1'b1; rgb_in = 12'hABC;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_hsync", 32'(hsync_out), 32'h1);
    check("pre_rst_rgb", 32'(rgb_out), 32'hABC);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb_out), 32'h0);
    check("mid_rst_hsync", 32'(hsync_out), 32'h0);
    check("mid_rst_vsync", 32'(vsync_out), 32'h0);
    check("mid_rst_sel", 32'(select_out), 32'h0);
    check("mid_rst_hcnt", 32'(hcount_out), 32'h0);
    check("mid_rst_ready", 32'(pos_ready), 32'h0);
    #1;
    rst = 1'b1;
    hsync = 1'b0; vsync = 1'b0; select = 1'b0;
    @(posedge clk); #1;
    check("ready_rerelease", 32'(pos_ready), 32'h1);
    commit_frame();
    probe("rst_pending_gone", 11'd500, 10'd400, 12'h555, 1'b1, 1'b0, 12'h000, 12'h555);
    probe("rst_active_gone", 11'd1014, 10'd100, 12'h556, 1'b1, 1'b0, 12'h000, 12'h556);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
